// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: widths and operand/result records shared by the normalization arbiter
package fp_norm_pkg;
   localparam int SIZE_DATA = 24;
   localparam int SIZE_EXP  = 8;
   localparam int SIZE_LOPD = 5;

   typedef struct packed {
      logic [SIZE_DATA-1:0] man;
      logic [SIZE_EXP-1:0]  exp;
      logic                 sign;
      logic                 src;
   } norm_op_t;

   typedef struct packed {
      logic [SIZE_DATA-1:0] man;
      logic [SIZE_EXP-1:0]  exp;
      logic                 sign;
      logic                 src;
      logic                 zero;
      logic                 underflow;
   } norm_res_t;
endpackage

// File: rtl/LOPD_24bit.sv
// LOPD_24bit: 24-bit leading-one detector
//   i_data          mantissa to scan
//   o_one_position  leading-zero count from bit 23, 31 when i_data is zero
//   o_zero_flag     i_data is all zero
module LOPD_24bit (
   input  logic [23:0] i_data,
   output logic [4:0]  o_one_position,
   output logic        o_zero_flag
);
   always_comb begin
      o_one_position = 5'd31;
      for (int i = 0; i < 24; i++)
         if (i_data[i]) o_one_position = 5'(23 - i);
      o_zero_flag = i_data == '0;
   end
endmodule

// File: rtl/fp_norm_arbiter.sv
// fp_norm_arbiter: two-lane round-robin scheduler sharing one leading-one detector and shifter
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_reqN_valid/o_reqN_ready    per-lane request handshake
//   i_reqN_man/exp/sign          per-lane unnormalized operand
//   o_valid/i_ready              result handshake
//   o_man/o_exp/o_sign/o_src     normalized result and its source lane
//   o_zero/o_underflow           result status
//   o_grant_cnt0/1               accepted-request counters, live only with FP_NORM_ARB_STATS_EN
module fp_norm_arbiter
   import fp_norm_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0_valid,
   input  logic                 i_req1_valid,
   output logic                 o_req0_ready,
   output logic                 o_req1_ready,
   input  logic [SIZE_DATA-1:0] i_req0_man,
   input  logic [SIZE_DATA-1:0] i_req1_man,
   input  logic [SIZE_EXP-1:0]  i_req0_exp,
   input  logic [SIZE_EXP-1:0]  i_req1_exp,
   input  logic                 i_req0_sign,
   input  logic                 i_req1_sign,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_man,
   output logic [SIZE_EXP-1:0]  o_exp,
   output logic                 o_sign,
   output logic                 o_src,
   output logic                 o_zero,
   output logic                 o_underflow,
   output logic [15:0]          o_grant_cnt0,
   output logic [15:0]          o_grant_cnt1
);
   logic                 adv, grant0, grant1, accept, uf;
   logic                 last_q, last_d;
   logic                 s1_valid_q, s1_valid_d;
   logic                 o_valid_q, o_valid_d;
   norm_op_t             op0, op1, s1_q, s1_d;
   norm_res_t            res, res_q, res_d;
   logic [SIZE_LOPD-1:0] lz, sh;
   logic [SIZE_EXP-1:0]  lz_ext;
   logic                 zero;

   LOPD_24bit u_lopd (
      .i_data         (s1_q.man),
      .o_one_position (lz),
      .o_zero_flag    (zero)
   );

   always_comb begin
      adv          = !o_valid_q | i_ready;
      // last_q=1 means lane 1 was granted last, so lane 0 wins a tie
      grant0       = i_req0_valid & (!i_req1_valid | last_q);
      grant1       = i_req1_valid & (!i_req0_valid | !last_q);
      o_req0_ready = adv & grant0 & !i_rst;
      o_req1_ready = adv & grant1 & !i_rst;
      accept       = o_req0_ready | o_req1_ready;
      last_d       = accept ? o_req1_ready : last_q;
      op0          = '{man: i_req0_man, exp: i_req0_exp, sign: i_req0_sign, src: 1'b0};
      op1          = '{man: i_req1_man, exp: i_req1_exp, sign: i_req1_sign, src: 1'b1};
      s1_valid_d   = adv ? (i_req0_valid | i_req1_valid) : s1_valid_q;
      s1_d         = !adv ? s1_q : o_req1_ready ? op1 : op0;
      lz_ext       = {{(SIZE_EXP-SIZE_LOPD){1'b0}}, lz};
      uf           = !zero & (lz_ext > s1_q.exp);
      // on underflow exp < lz <= 23, so it fits the shift-amount width
      sh           = uf ? s1_q.exp[SIZE_LOPD-1:0] : lz;
      res.man       = zero ? '0 : s1_q.man << sh;
      res.exp       = (zero | uf) ? '0 : s1_q.exp - lz_ext;
      res.sign      = s1_q.sign;
      res.src       = s1_q.src;
      res.zero      = zero;
      res.underflow = uf;
      o_valid_d    = adv ? s1_valid_q : o_valid_q;
      res_d        = (adv & s1_valid_q) ? res : res_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_q     <= 1'b1;
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         o_valid_q  <= 1'b0;
         res_q      <= '0;
      end else begin
         last_q     <= last_d;
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         o_valid_q  <= o_valid_d;
         res_q      <= res_d;
      end
   end

   assign o_valid     = o_valid_q;
   assign o_man       = res_q.man;
   assign o_exp       = res_q.exp;
   assign o_sign      = res_q.sign;
   assign o_src       = res_q.src;
   assign o_zero      = res_q.zero;
   assign o_underflow = res_q.underflow;

`ifdef FP_NORM_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = (o_req0_ready && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
      cnt1_d = (o_req1_ready && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign o_grant_cnt0 = cnt0_q;
   assign o_grant_cnt1 = cnt1_q;
`else
   assign o_grant_cnt0 = '0;
   assign o_grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_fp_norm_arbiter.sv
// tb_fp_norm_arbiter: randomized scoreboard bench for fp_norm_arbiter
module tb_fp_norm_arbiter;
   logic        clk = 0, rst = 1;
   logic        v0 = 0, v1 = 0, rdy0, rdy1, o_valid, i_ready = 0;
   logic [23:0] m0 = 0, m1 = 0, o_man;
   logic [7:0]  e0 = 0, e1 = 0, o_exp;
   logic        s0 = 0, s1 = 0, o_sign, o_src, o_zero, o_uf;
   logic [15:0] cnt0, cnt1;

   always #5 clk = ~clk;

   fp_norm_arbiter dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(v0), .i_req1_valid(v1),
      .o_req0_ready(rdy0), .o_req1_ready(rdy1),
      .i_req0_man(m0), .i_req1_man(m1),
      .i_req0_exp(e0), .i_req1_exp(e1),
      .i_req0_sign(s0), .i_req1_sign(s1),
      .o_valid(o_valid), .i_ready(i_ready),
      .o_man(o_man), .o_exp(o_exp), .o_sign(o_sign), .o_src(o_src),
      .o_zero(o_zero), .o_underflow(o_uf),
      .o_grant_cnt0(cnt0), .o_grant_cnt1(cnt1)
   );

   int n_chk = 0, n_pass = 0;
   logic [35:0] sb[$];
   bit m_s1v = 0, m_s2v = 0, m_last = 1;
   int m_cnt0 = 0, m_cnt1 = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // reference normalization straight from the rules: {man, exp, sign, src, zero, underflow}
   function automatic logic [35:0] ref_norm(input logic [23:0] m, input logic [7:0] e,
                                            input logic s, input logic src);
      int lz = 0;
      if (m == 0) return {24'h0, 8'h0, s, src, 1'b1, 1'b0};
      while (m < (24'h800000 >> lz)) lz++;
      if (lz > int'(e)) return {24'(m << e), 8'h0, s, src, 1'b0, 1'b1};
      return {24'(m << lz), 8'(int'(e) - lz), s, src, 1'b0, 1'b0};
   endfunction

   task automatic cyc(input bit a0, input logic [23:0] am0, input logic [7:0] ae0, input bit as0,
                      input bit a1, input logic [23:0] am1, input logic [7:0] ae1, input bit as1,
                      input bit r);
      bit adv, g0, g1;
      @(negedge clk);
      v0 = a0; m0 = am0; e0 = ae0; s0 = as0;
      v1 = a1; m1 = am1; e1 = ae1; s1 = as1;
      i_ready = r;
      #4;
      adv = !m_s2v || r;
      g0 = a0 && (!a1 || m_last);
      g1 = a1 && (!a0 || !m_last);
      chk("ready", {rdy1, rdy0}, {adv && g1, adv && g0});
      chk("o_valid", o_valid, m_s2v);
      if (adv) begin
         if (g0) begin
            sb.push_back(ref_norm(am0, ae0, as0, 1'b0));
            if (m_cnt0 < 65535) m_cnt0++;
            m_last = 0;
         end else if (g1) begin
            sb.push_back(ref_norm(am1, ae1, as1, 1'b1));
            if (m_cnt1 < 65535) m_cnt1++;
            m_last = 1;
         end
         m_s2v = m_s1v;
         m_s1v = a0 || a1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic model_reset();
      m_s1v = 0; m_s2v = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      sb.delete();
   endtask

   task automatic chk_cnt(input string tag);
`ifdef FP_NORM_ARB_STATS_EN
      chk({tag, "_cnt0"}, cnt0, 64'(m_cnt0));
      chk({tag, "_cnt1"}, cnt1, 64'(m_cnt1));
`else
      chk({tag, "_cnt0"}, cnt0, 0);
      chk({tag, "_cnt1"}, cnt1, 0);
`endif
   endtask

   // monitor: any presented result must equal the oldest expected one, and it is retired on i_ready
   always begin
      @(negedge clk);
      #4;
      if (!rst && o_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_result: got %0h expected none", {o_man, o_exp, o_sign, o_src, o_zero, o_uf});
         end else begin
            chk("result", {o_man, o_exp, o_sign, o_src, o_zero, o_uf}, sb[0]);
            if (i_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [23:0] rm0, rm1;
      logic [7:0]  re0, re1;
      repeat (2) @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_man", o_man, 0);
      chk("rst_exp", o_exp, 0);
      chk("rst_sign_src", {o_sign, o_src}, 0);
      chk("rst_zero_uf", {o_zero, o_uf}, 0);
      chk_cnt("rst");
      rst = 0;

      cyc(1, 24'h001234, 8'd40, 0, 0, 0, 0, 0, 1);
      idle(3);

      repeat (4) cyc(1, 24'($urandom), 8'($urandom), 1'($urandom), 1, 24'($urandom), 8'($urandom), 1'($urandom), 1);
      idle(3);

      cyc(0, 0, 0, 0, 1, 24'h000100, 8'd5, 1, 1);
      idle(3);
      cyc(1, 24'h0, 8'd100, 1, 0, 0, 0, 0, 1);
      idle(3);

      repeat (3) cyc(1, 24'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 1);
      repeat (3) cyc(1, 24'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0);
      repeat (2) cyc(1, 24'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 1);
      idle(3);

      repeat (3) cyc(1, 24'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      v0 = 1; v1 = 1;
      #2 rst = 1;
      #1;
      chk("midrst_valid", o_valid, 0);
      chk("midrst_ready", {rdy1, rdy0}, 0);
      model_reset();
      chk_cnt("midrst");
      @(negedge clk);
      v0 = 0; v1 = 0;
      rst = 0;
      cyc(1, 24'h000F00, 8'd30, 0, 1, 24'h00F000, 8'd30, 1, 1);
      cyc(1, 24'h000F00, 8'd30, 0, 1, 24'h00F000, 8'd30, 1, 1);
      idle(3);

      repeat (400) begin
         rm0 = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom >> $urandom_range(0, 31));
         rm1 = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom >> $urandom_range(0, 31));
         re0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 24)) : 8'($urandom);
         re1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 24)) : 8'($urandom);
         cyc($urandom_range(0, 2) != 0, rm0, re0, 1'($urandom),
             $urandom_range(0, 2) != 0, rm1, re1, 1'($urandom),
             $urandom_range(0, 3) != 0);
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
      chk("drain", sb.size(), 0);
      chk_cnt("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
